// File: rtl/mem_arbiter_fsm.sv
// Arbitrates the shared pipelined main memory between I-cache fills, D-cache fills
// and D-cache write-through stores, one transaction at a time.
module mem_arbiter_fsm #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int BLK_WDS = 8,
    parameter int MEM_LAT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       icache_miss,
    input  logic [ADDR_W-1:0]          icache_miss_addr,
    input  logic                       dcache_miss,
    input  logic [ADDR_W-1:0]          dcache_miss_addr,
    input  logic                       dcache_wr_req,
    input  logic [ADDR_W-1:0]          dcache_wr_addr,
    input  logic [DATA_W-1:0]          dcache_wr_data,
    output logic                       mem_enable,
    output logic                       mem_wr,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       mem_data_valid,
    output logic [DATA_W-1:0]          fill_data,
    output logic [$clog2(BLK_WDS)-1:0] fill_word,
    output logic                       fill_we_i,
    output logic                       fill_we_d,
    output logic                       fill_done_i,
    output logic                       fill_done_d,
    output logic                       wr_ack,
    output logic                       busy
);

    localparam int WI = $clog2(BLK_WDS);
    localparam logic [WI-1:0] LAST_WD = WI'(BLK_WDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WI-1:0]     ic, rc;
    logic              issue_done;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              owner_d;
    logic              last_ret;

    // A fill finishes on the return that carries the final word of the block.
    assign last_ret = (state == FILL) && mem_data_valid && (rc == LAST_WD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ic         <= '0;
            rc         <= '0;
            issue_done <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            owner_d    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    ic         <= '0;
                    rc         <= '0;
                    issue_done <= 1'b0;
                    if (dcache_wr_req) begin
                        addr_q  <= dcache_wr_addr;
                        wdata_q <= dcache_wr_data;
                        owner_d <= 1'b1;
                    end else if (dcache_miss) begin
                        addr_q  <= dcache_miss_addr;
                        owner_d <= 1'b1;
                    end else if (icache_miss) begin
                        addr_q  <= icache_miss_addr;
                        owner_d <= 1'b0;
                    end
                end
                FILL: begin
                    if (last_ret) begin
                        ic         <= '0;
                        rc         <= '0;
                        issue_done <= 1'b0;
                    end else begin
                        // Issue counter parks on the last word; the flag stops further reads.
                        if (!issue_done) begin
                            if (ic == LAST_WD) issue_done <= 1'b1;
                            else               ic         <= ic + 1'b1;
                        end
                        if (mem_data_valid) rc <= rc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        fill_data   = mem_rdata;
        fill_word   = '0;
        fill_we_i   = 1'b0;
        fill_we_d   = 1'b0;
        fill_done_i = 1'b0;
        fill_done_d = 1'b0;
        wr_ack      = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (dcache_wr_req)                   state_nxt = WRITE;
                else if (dcache_miss || icache_miss) state_nxt = FILL;
            end
            WRITE: begin
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = addr_q;
                mem_wdata  = wdata_q;
                wr_ack     = 1'b1;
                state_nxt  = IDLE;
            end
            FILL: begin
                if (!issue_done) begin
                    mem_enable = 1'b1;
                    mem_addr   = {addr_q[ADDR_W-1:WI+1], ic, 1'b0};
                end
                // Returns arrive in issue order, so the return count is the word index.
                if (mem_data_valid) begin
                    fill_word = rc;
                    fill_we_d = owner_d;
                    fill_we_i = !owner_d;
                end
                if (last_ret) begin
                    fill_done_d = owner_d;
                    fill_done_i = !owner_d;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter_fsm.sv
// Directed bench for mem_arbiter_fsm with a MEM_LAT-deep pipelined memory model.
module tb_mem_arbiter_fsm;

    localparam int MEM_LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_miss, dcache_miss, dcache_wr_req;
    logic [15:0] icache_miss_addr, dcache_miss_addr, dcache_wr_addr, dcache_wr_data;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_data_valid;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        fill_we_i, fill_we_d, fill_done_i, fill_done_d, wr_ack, busy;

    int checks   = 0;
    int failures = 0;

    logic        pipe_v [MEM_LAT];
    logic [15:0] pipe_a [MEM_LAT];
    logic        spur = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter_fsm #(.ADDR_W(16), .DATA_W(16), .BLK_WDS(8), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst),
        .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
        .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
        .dcache_wr_req(dcache_wr_req), .dcache_wr_addr(dcache_wr_addr),
        .dcache_wr_data(dcache_wr_data),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
        .fill_data(fill_data), .fill_word(fill_word),
        .fill_we_i(fill_we_i), .fill_we_d(fill_we_d),
        .fill_done_i(fill_done_i), .fill_done_d(fill_done_d),
        .wr_ack(wr_ack), .busy(busy)
    );

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    // Memory model: a read issued in cycle c returns in cycle c+MEM_LAT; it ignores rst.
    always_ff @(posedge clk) begin
        pipe_v[0] <= mem_enable && !mem_wr;
        pipe_a[0] <= mem_addr;
        for (int k = 1; k < MEM_LAT; k++) begin
            pipe_v[k] <= pipe_v[k-1];
            pipe_a[k] <= pipe_a[k-1];
        end
    end

    initial begin
        for (int k = 0; k < MEM_LAT; k++) begin
            pipe_v[k] = 1'b0;
            pipe_a[k] = 16'h0;
        end
    end

    assign mem_data_valid = pipe_v[MEM_LAT-1] | spur;
    assign mem_rdata      = pipe_v[MEM_LAT-1] ? mem_val(pipe_a[MEM_LAT-1]) : 16'h0000;

    // Called at an IDLE negedge with the owner's request already raised; returns at the next IDLE negedge.
    task automatic run_fill(input logic is_d, input logic [15:0] base, input logic drop_early);
        int   issues   = 0;
        int   words    = 0;
        int   done_cyc = -1;
        logic we_own, we_oth, done_own;
        @(negedge clk);
        for (int cyc = 0; cyc < 20 && done_cyc < 0; cyc++) begin
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL fill_busy cyc=%0d got=%b want=1", cyc, busy);
            end
            if (mem_enable) begin
                checks++;
                if (mem_wr !== 1'b0 || mem_addr !== 16'(base + 2 * issues)) begin
                    failures++;
                    $display("FAIL fill_issue cyc=%0d got wr=%b addr=%h want wr=0 addr=%h",
                             cyc, mem_wr, mem_addr, 16'(base + 2 * issues));
                end
                issues++;
            end
            we_own   = is_d ? fill_we_d : fill_we_i;
            we_oth   = is_d ? fill_we_i : fill_we_d;
            done_own = is_d ? fill_done_d : fill_done_i;
            checks++;
            if (we_oth !== 1'b0 || (is_d ? fill_done_i : fill_done_d) !== 1'b0) begin
                failures++;
                $display("FAIL fill_wrong_owner cyc=%0d got we=%b want we=0", cyc, we_oth);
            end
            if (we_own) begin
                checks++;
                if (fill_word !== 3'(words) || fill_data !== mem_val(16'(base + 2 * words))) begin
                    failures++;
                    $display("FAIL fill_word cyc=%0d got word=%0d data=%h want word=%0d data=%h",
                             cyc, fill_word, fill_data, words, mem_val(16'(base + 2 * words)));
                end
                checks++;
                if (done_own !== (words == 7)) begin
                    failures++;
                    $display("FAIL fill_done cyc=%0d got=%b want=%b", cyc, done_own, words == 7);
                end
                if (done_own) begin
                    done_cyc = cyc;
                    if (is_d) dcache_miss = 1'b0;
                    else      icache_miss = 1'b0;
                end
                words++;
            end else begin
                checks++;
                if (done_own !== 1'b0) begin
                    failures++;
                    $display("FAIL fill_done_novalid cyc=%0d got=%b want=0", cyc, done_own);
                end
            end
            if (cyc == 1) begin
                if (is_d) dcache_miss_addr = ~base;
                else      icache_miss_addr = ~base;
            end
            if (drop_early && cyc == 3) begin
                if (is_d) dcache_miss = 1'b0;
                else      icache_miss = 1'b0;
            end
            if (done_cyc < 0) @(negedge clk);
        end
        checks++;
        if (done_cyc != 11 || issues != 8 || words != 8) begin
            failures++;
            $display("FAIL fill_summary got done_cyc=%0d issues=%0d words=%0d want 11/8/8",
                     done_cyc, issues, words);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_enable !== 1'b0) begin
            failures++;
            $display("FAIL fill_idle_after got busy=%b en=%b want 0/0", busy, mem_enable);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        icache_miss = 1'b1; icache_miss_addr = 16'h1111;
        dcache_miss = 1'b0; dcache_miss_addr = 16'h0;
        dcache_wr_req = 1'b0; dcache_wr_addr = 16'h0; dcache_wr_data = 16'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, mem_enable, mem_wr, fill_we_i, fill_we_d, fill_done_i, fill_done_d, wr_ack} !== 8'h00 ||
            mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b en=%b addr=%h want all 0", busy, mem_enable, mem_addr);
        end
        icache_miss = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_enable !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got busy=%b en=%b want 0/0", busy, mem_enable);
        end
    endtask

    task automatic test_i_fill();
        icache_miss = 1'b1; icache_miss_addr = 16'h1234;
        run_fill(1'b0, 16'h1230, 1'b0);
    endtask

    task automatic test_d_fill_drop();
        dcache_miss = 1'b1; dcache_miss_addr = 16'h00F2;
        run_fill(1'b1, 16'h00F0, 1'b1);
    endtask

    task automatic test_priority();
        icache_miss = 1'b1;   icache_miss_addr = 16'h0A5E;
        dcache_miss = 1'b1;   dcache_miss_addr = 16'h0312;
        dcache_wr_req = 1'b1; dcache_wr_addr = 16'h0040; dcache_wr_data = 16'hBEEF;
        @(negedge clk);
        checks++;
        if (mem_enable !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h0040 ||
            mem_wdata !== 16'hBEEF || wr_ack !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL prio_write got en=%b wr=%b addr=%h data=%h ack=%b want 1/1/0040/beef/1",
                     mem_enable, mem_wr, mem_addr, mem_wdata, wr_ack);
        end
        spur = 1'b1;
        #1;
        checks++;
        if (fill_we_i !== 1'b0 || fill_we_d !== 1'b0) begin
            failures++;
            $display("FAIL write_spurious_valid got we_i=%b we_d=%b want 0/0", fill_we_i, fill_we_d);
        end
        spur = 1'b0;
        dcache_wr_req = 1'b0;
        dcache_wr_addr = 16'hFFFF; dcache_wr_data = 16'h0000;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wr_ack !== 1'b0) begin
            failures++;
            $display("FAIL prio_idle_between got busy=%b ack=%b want 0/0", busy, wr_ack);
        end
        run_fill(1'b1, 16'h0310, 1'b0);
        run_fill(1'b0, 16'h0A50, 1'b0);
    endtask

    task automatic test_reset_mid_fill();
        int vcnt = 0;
        icache_miss = 1'b1; icache_miss_addr = 16'h2000;
        @(negedge clk);
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || mem_enable !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_fill got busy=%b en=%b want 1/1", busy, mem_enable);
        end
        rst = 1'b1;
        icache_miss = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || mem_enable !== 1'b0 || mem_addr !== 16'h0) begin
            failures++;
            $display("FAIL rst_mid_fill got busy=%b en=%b addr=%h want 0/0/0000", busy, mem_enable, mem_addr);
        end
        for (int i = 0; i < 7; i++) begin
            if (mem_data_valid) vcnt++;
            checks++;
            if (fill_we_i !== 1'b0 || fill_we_d !== 1'b0 || fill_done_i !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL rst_stale_valid i=%0d got we_i=%b busy=%b want 0/0", i, fill_we_i, busy);
            end
            @(negedge clk);
        end
        checks++;
        if (vcnt < 3) begin
            failures++;
            $display("FAIL rst_trailing_count got=%0d want>=3", vcnt);
        end
        icache_miss = 1'b1; icache_miss_addr = 16'h2006;
        run_fill(1'b0, 16'h2000, 1'b0);
    endtask

    task automatic test_back_to_back();
        dcache_miss = 1'b1; dcache_miss_addr = 16'h0100;
        run_fill(1'b1, 16'h0100, 1'b0);
        dcache_miss = 1'b1; dcache_miss_addr = 16'h0200;
        run_fill(1'b1, 16'h0200, 1'b0);
    endtask

    task automatic test_spurious_idle();
        spur = 1'b1;
        #1;
        checks++;
        if (fill_we_i !== 1'b0 || fill_we_d !== 1'b0 || fill_done_i !== 1'b0 ||
            fill_done_d !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_spurious got we_i=%b we_d=%b busy=%b want 0/0/0", fill_we_i, fill_we_d, busy);
        end
        @(negedge clk);
        spur = 1'b0;
        checks++;
        if (busy !== 1'b0 || mem_enable !== 1'b0) begin
            failures++;
            $display("FAIL idle_stays got busy=%b en=%b want 0/0", busy, mem_enable);
        end
    endtask

    initial begin
        test_reset();
        test_i_fill();
        test_d_fill_drop();
        test_priority();
        test_reset_mid_fill();
        test_back_to_back();
        test_spurious_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
